// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage and its pipeline register.
package fetch_stage_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0] InsnPath;
  typedef logic [31:0] InsnAddrPath;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_HOLD = 2'd3
  } FetchStatePath;

  localparam InsnPath     NOP_INSN = 32'h0000_0000;
  localparam InsnAddrPath PC_STEP  = 32'd4;

  // Instruction addresses are word aligned; the two low bits of a redirect are dropped.
  function automatic InsnAddrPath word_align(input InsnAddrPath addr);
    return addr & ~InsnAddrPath'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus. The fetch stage is the master.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic        imemReq;
  InsnAddrPath imemAddr;
  logic        imemReady;
  InsnPath     imemInsn;

  modport master (output imemReq, output imemAddr, input imemReady, input imemInsn);
  modport slave  (input imemReq, input imemAddr, output imemReady, output imemInsn);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a new instruction, hold, or flush to a bubble.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  InsnPath     load_insn,
  input  InsnAddrPath load_pc_plus4,
  output logic        valid,
  output InsnPath     insn,
  output InsnAddrPath pc_plus4
);

  // Bubble wins over load; with neither asserted the register holds.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid    <= FALSE;
      insn     <= NOP_INSN;
      pc_plus4 <= '0;
    end else if (load) begin
      valid    <= TRUE;
      insn     <= load_insn;
      pc_plus4 <= load_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, one-entry skid buffer and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter InsnAddrPath RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 brTaken,
  input  InsnAddrPath          brTarget,
  fetch_stage_if.master        imem,
  output logic                 ifidValid,
  output InsnPath              ifidInsn,
  output InsnAddrPath          ifidPcPlus4,
  output logic [CNT_WIDTH-1:0] fetchCount
);

  FetchStatePath        state_reg, state_next;
  InsnAddrPath          pc_reg, pc_next;
  InsnPath              skid_reg;
  logic                 pend_valid_reg, pend_valid_next;
  InsnAddrPath          pend_target_reg, pend_target_next;
  logic [CNT_WIDTH-1:0] count_reg;

  logic        imem_req;
  logic        skid_load;
  logic        count_inc;
  logic        ifid_load;
  logic        ifid_bubble;
  InsnPath     ifid_load_insn;
  InsnAddrPath br_target;
  InsnAddrPath pc_plus4;

  assign br_target = word_align(brTarget);
  assign pc_plus4  = pc_reg + PC_STEP;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= FETCH_BOOT;
    else     state_reg <= state_next;
  end

  // Next-state logic: a miss in RUN waits; a word returned under stall parks in HOLD.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      FETCH_BOOT: state_next = FETCH_RUN;
      FETCH_RUN: begin
        if (!brTaken && !stall && !imem.imemReady) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem.imemReady) begin
          if (brTaken || pend_valid_reg || !stall) state_next = FETCH_RUN;
          else                                     state_next = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (brTaken || !stall) state_next = FETCH_RUN;
      end
      default: state_next = FETCH_BOOT;
    endcase
  end

  // Output/control logic: PC update, IF/ID control, skid capture and pending redirect.
  always_comb begin
    imem_req         = FALSE;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    skid_load        = FALSE;
    count_inc        = FALSE;
    ifid_load        = FALSE;
    ifid_bubble      = FALSE;
    ifid_load_insn   = imem.imemInsn;
    unique case (state_reg)
      FETCH_BOOT: ifid_bubble = TRUE;
      FETCH_RUN: begin
        imem_req = !stall;
        if (brTaken) begin
          pc_next     = br_target;
          ifid_bubble = TRUE;
        end else if (!stall) begin
          if (imem.imemReady) begin
            ifid_load = TRUE;
            pc_next   = pc_plus4;
            count_inc = TRUE;
          end else begin
            ifid_bubble = TRUE;
          end
        end
      end
      FETCH_WAIT: begin
        imem_req = TRUE;
        if (imem.imemReady) begin
          pend_valid_next = FALSE;
          // A redirect arriving with the data is the newest one, so it beats a pending one.
          if (brTaken) begin
            pc_next     = br_target;
            ifid_bubble = TRUE;
          end else if (pend_valid_reg) begin
            pc_next     = pend_target_reg;
            ifid_bubble = TRUE;
          end else if (!stall) begin
            ifid_load = TRUE;
            pc_next   = pc_plus4;
            count_inc = TRUE;
          end else begin
            skid_load = TRUE;
          end
        end else begin
          // The outstanding access cannot be cancelled, so remember the redirect.
          if (brTaken) begin
            pend_valid_next  = TRUE;
            pend_target_next = br_target;
          end
          if (!stall) ifid_bubble = TRUE;
        end
      end
      FETCH_HOLD: begin
        ifid_load_insn = skid_reg;
        if (brTaken) begin
          pc_next     = br_target;
          ifid_bubble = TRUE;
        end else if (!stall) begin
          ifid_load = TRUE;
          pc_next   = pc_plus4;
          count_inc = TRUE;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: PC, skid word, pending redirect and fetch counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      skid_reg        <= NOP_INSN;
      pend_valid_reg  <= FALSE;
      pend_target_reg <= '0;
      count_reg       <= '0;
    end else begin
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      if (skid_load) skid_reg <= imem.imemInsn;
      if (count_inc) count_reg <= count_reg + 1'b1;
    end
  end

  ifid_reg u_ifid_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .load_insn     (ifid_load_insn),
    .load_pc_plus4 (pc_plus4),
    .valid         (ifidValid),
    .insn          (ifidInsn),
    .pc_plus4      (ifidPcPlus4)
  );

  assign imem.imemReq  = imem_req;
  assign imem.imemAddr = pc_reg;
  assign fetchCount    = count_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        ready;
  logic        ifidValid;
  logic [31:0] ifidInsn;
  logic [31:0] ifidPcPlus4;
  logic [31:0] fetchCount;

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();

  // Memory returns the word index of the requested address.
  assign bus.imemReady = ready;
  assign bus.imemInsn  = bus.imemAddr >> 2;

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .brTaken     (brTaken),
    .brTarget    (brTarget),
    .imem        (bus.master),
    .ifidValid   (ifidValid),
    .ifidInsn    (ifidInsn),
    .ifidPcPlus4 (ifidPcPlus4),
    .fetchCount  (fetchCount)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_pc, m_skid, m_insn, m_pp4, m_count;
  bit          m_booted, m_outstanding, m_held, m_valid;
  logic [31:0] m_pend[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_skid = 32'h0; m_insn = 32'h0; m_pp4 = 32'h0; m_count = 32'h0;
    m_booted = 0; m_outstanding = 0; m_held = 0; m_valid = 0;
    m_pend.delete();
  endtask

  task automatic m_bubble();
    m_valid = 0; m_insn = 32'h0; m_pp4 = 32'h0;
  endtask

  task automatic m_deliver(input logic [31:0] w);
    m_valid = 1; m_insn = w; m_pp4 = m_pc + 32'd4;
    m_pc = m_pc + 32'd4; m_count = m_count + 32'd1;
  endtask

  task automatic m_redirect(input logic [31:0] t);
    m_pc = t; m_bubble();
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registers.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] t, input bit rd);
    logic [31:0] tgt;
    logic [31:0] word;
    bit          exp_req;
    @(negedge clk);
    rst = r; stall = s; brTaken = b; brTarget = t; ready = rd;
    #1;
    exp_req = m_booted && !m_held && (m_outstanding || !s);
    check("imemReq", 32'(bus.imemReq), 32'(exp_req));
    check("imemAddr", bus.imemAddr, m_pc);
    @(posedge clk);
    tgt  = t & 32'hFFFF_FFFC;
    word = m_pc >> 2;
    if (r) begin
      m_reset();
    end else if (!m_booted) begin
      m_booted = 1; m_bubble();
    end else if (m_held) begin
      if (b) begin m_held = 0; m_redirect(tgt); end
      else if (!s) begin m_held = 0; m_deliver(m_skid); end
    end else if (m_outstanding) begin
      if (rd) begin
        m_outstanding = 0;
        if (b) begin m_redirect(tgt); m_pend.delete(); end
        else if (m_pend.size() > 0) begin m_redirect(m_pend[$]); m_pend.delete(); end
        else if (!s) m_deliver(word);
        else begin m_skid = word; m_held = 1; end
      end else begin
        if (b) m_pend.push_back(tgt);
        if (!s) m_bubble();
      end
    end else begin
      if (b) m_redirect(tgt);
      else if (!s) begin
        if (rd) m_deliver(word);
        else begin m_bubble(); m_outstanding = 1; end
      end
    end
    #1;
    check("ifidValid", 32'(ifidValid), 32'(m_valid));
    check("ifidInsn", ifidInsn, m_insn);
    check("ifidPcPlus4", ifidPcPlus4, m_pp4);
    check("fetchCount", fetchCount, m_count);
  endtask

  initial begin
    bit          r_rst, r_stall, r_br, r_rdy;
    logic [31:0] r_tgt;
    rst = 1'b1; stall = 1'b0; brTaken = 1'b0; brTarget = 32'h0; ready = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset state and in-order streaming after the boot bubble.
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Hazard stall for three cycles at pc=8, then resume.
    repeat (3) step(0, 1, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Redirect together with stall: redirect wins.
    step(0, 1, 1, 32'h40, 1);
    step(0, 0, 0, 32'h0, 1);
    // Slow memory at pc=4 with a redirect arriving during the wait.
    step(0, 0, 1, 32'h4, 1);
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'h100, 0);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Word returns under stall: parks in the skid buffer, released later.
    step(0, 0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 1);
    step(0, 1, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    // PC wrap at the top of the address space; low target bits are ignored.
    step(0, 0, 1, 32'hFFFF_FFFE, 1);
    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    // Reset in the middle of an outstanding access.
    step(0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 99) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_br    = ($urandom_range(0, 9) == 0);
      r_rdy   = ($urandom_range(0, 9) < 6);
      r_tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom_range(0, 4095));
      step(r_rst, r_stall, r_br, r_tgt, r_rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
